// File: rtl/ap_cam_pkg.sv
// Shared types and constants for the associative-processor CAM array.
// Contents:
//   cam_op_e         command opcodes (WRITE, READ, COMPARE, TAG_WRITE)
//   cam_state_e      control FSM states (IDLE, RESOLVE, RESP)
//   RESP_LAT_*       cycles from command acceptance to resp_valid
package ap_cam_pkg;

  typedef enum logic [1:0] {
    OpWrite    = 2'd0,
    OpRead     = 2'd1,
    OpCompare  = 2'd2,
    OpTagWrite = 2'd3
  } cam_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StResolve,
    StResp
  } cam_state_e;

  localparam int unsigned RESP_LAT_COMPARE = 2;
  localparam int unsigned RESP_LAT_RW      = 1;

endpackage

// File: rtl/ap_cam_row.sv
// One CAM row: word storage, masked compare against a key, masked tag-write.
// Ports:
//   clock, rst          clock and synchronous active-high reset (row clears to 0)
//   wr_en, wr_data      full-word write
//   tw_en, tw_data,     masked write: bits selected by tw_mask take tw_data
//   tw_mask
//   key, mask           compare key and bit-select
//   row                 stored word
//   hit                 combinational: row equals key on every masked bit
module ap_cam_row #(
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 tw_en,
  input  logic [WORD_SIZE-1:0] tw_data,
  input  logic [WORD_SIZE-1:0] tw_mask,
  input  logic [WORD_SIZE-1:0] key,
  input  logic [WORD_SIZE-1:0] mask,
  output logic [WORD_SIZE-1:0] row,
  output logic                 hit
);

  always_ff @(posedge clock) begin
    if (rst) begin
      row <= '0;
    end else if (wr_en) begin
      row <= wr_data;
    end else if (tw_en) begin
      row <= (row & ~tw_mask) | (tw_data & tw_mask);
    end
  end

  // An all-zero mask makes every row hit.
  assign hit = ((row ^ key) & mask) == '0;

endmodule

// File: rtl/ap_cam_array.sv
// Associative-processor CAM array with a valid/ready command and response port.
// Commands: WRITE/READ a row, COMPARE all rows against a masked key into a
// registered tag vector, TAG_WRITE masked data into every tagged row.
// Ports:
//   clock, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_op, cmd_addr, cmd_data,      opcode, row index, data or key, bit-select
//   cmd_mask
//   resp_valid/resp_ready            response handshake
//   resp_err, resp_rdata             out-of-range flag, READ data
//   tags, any_match, first_idx       match vector and its summaries
//   match_cnt                        popcount of tags (only with CAM_MATCH_COUNT_EN)
// Build option: define CAM_MATCH_COUNT_EN to add the match_cnt port and popcount.
module ap_cam_array
  import ap_cam_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned CELL_QUANT = 128,
  parameter int unsigned ADDR_W     = $clog2(CELL_QUANT)
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [WORD_SIZE-1:0]  cmd_data,
  input  logic [WORD_SIZE-1:0]  cmd_mask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_err,
  output logic [WORD_SIZE-1:0]  resp_rdata,
  output logic [CELL_QUANT-1:0] tags,
  output logic                  any_match,
  output logic [ADDR_W-1:0]     first_idx
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_W:0]       match_cnt
`endif
);

  cam_state_e           state_q, state_d;
  cam_op_e              op;
  logic                 accept;
  logic                 addr_oob;
  logic [WORD_SIZE-1:0] rows [CELL_QUANT];
  logic [CELL_QUANT-1:0] hits;
  logic [WORD_SIZE-1:0] rd_word;
  logic [ADDR_W-1:0]    first_d;

  assign cmd_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign accept     = cmd_valid && cmd_ready;
  assign op         = cam_op_e'(cmd_op);
  assign addr_oob   = 32'(cmd_addr) >= CELL_QUANT;

  // All row actions happen on the acceptance edge, so nothing from the command
  // needs to be held while busy; later input changes cannot reach the array.
  for (genvar i = 0; i < CELL_QUANT; i++) begin : g_row
    ap_cam_row #(
      .WORD_SIZE(WORD_SIZE)
    ) u_row (
      .clock  (clock),
      .rst    (rst),
      .wr_en  (accept && (op == OpWrite) && (cmd_addr == ADDR_W'(i))),
      .wr_data(cmd_data),
      .tw_en  (accept && (op == OpTagWrite) && tags[i]),
      .tw_data(cmd_data),
      .tw_mask(cmd_mask),
      .key    (cmd_data),
      .mask   (cmd_mask),
      .row    (rows[i]),
      .hit    (hits[i])
    );
  end

  // Out-of-range addresses match no row and read as zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < CELL_QUANT; i++) begin
      if (32'(cmd_addr) == i) rd_word = rows[i];
    end
  end

  // Scan downwards so the lowest set tag wins.
  always_comb begin
    first_d = '0;
    for (int i = int'(CELL_QUANT) - 1; i >= 0; i--) begin
      if (tags[i]) first_d = ADDR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (op == OpCompare) ? StResolve : StResp;
      end
      StResolve: state_d = StResp;
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= StIdle;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      tags       <= '0;
      any_match  <= 1'b0;
      first_idx  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        resp_err   <= ((op == OpWrite) || (op == OpRead)) && addr_oob;
        resp_rdata <= (op == OpRead) ? rd_word : '0;
        if (op == OpCompare) tags <= hits;
      end
      if (state_q == StResolve) begin
        any_match <= |tags;
        first_idx <= first_d;
      end
    end
  end

`ifdef CAM_MATCH_COUNT_EN
  logic [ADDR_W:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < CELL_QUANT; i++) begin
      cnt_d = cnt_d + (ADDR_W + 1)'(tags[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (state_q == StResolve) begin
      match_cnt <= cnt_d;
    end
  end
`else
  // Without the counter the resolve stage only refreshes any_match/first_idx.
`endif

endmodule

// File: tb/tb_ap_cam_array.sv
// Directed self-checking bench for ap_cam_array (CELL_QUANT=100, WORD_SIZE=8).
module tb_ap_cam_array;

  localparam int unsigned WS = 8;
  localparam int unsigned CQ = 100;
  localparam int unsigned AW = 7;

  logic          clock = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [WS-1:0] cmd_data;
  logic [WS-1:0] cmd_mask;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_err;
  logic [WS-1:0] resp_rdata;
  logic [CQ-1:0] tags;
  logic          any_match;
  logic [AW-1:0] first_idx;
`ifdef CAM_MATCH_COUNT_EN
  logic [AW:0]   match_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ap_cam_array #(
    .WORD_SIZE (WS),
    .CELL_QUANT(CQ),
    .ADDR_W    (AW)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_mask  (cmd_mask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_err  (resp_err),
    .resp_rdata(resp_rdata),
    .tags      (tags),
    .any_match (any_match),
    .first_idx (first_idx)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  // Called at posedge+1 with the DUT idle; the next posedge accepts.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr,
                      input logic [WS-1:0] data, input logic [WS-1:0] mask);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Cycles after acceptance until resp_valid is seen; -1 if it never shows.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [WS-1:0] data, input logic [WS-1:0] mask,
                         output int lat, output logic [WS-1:0] rdata, output logic err);
    send(op, addr, data, mask);
    wait_resp(lat);
    rdata = resp_rdata;
    err   = resp_err;
    finish_resp();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = '0;
    cmd_data = '1; cmd_mask = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    n_checks++;
    if (resp_err !== 1'b0 || resp_rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_resp: got err=%b rdata=%h want 0/00", resp_err, resp_rdata);
    end
    n_checks++;
    if (tags !== '0 || any_match !== 1'b0 || first_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_match: got tags=%h any=%b first=%0d want 0", tags, any_match, first_idx);
    end
`ifdef CAM_MATCH_COUNT_EN
    n_checks++;
    if (match_cnt !== '0) begin
      n_fail++; $display("FAIL reset_match_cnt: got %0d want 0", match_cnt);
    end
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic test_write_read();
    int lat; logic [WS-1:0] rd; logic err;
    run_cmd(2'd0, 7'd5, 8'hA5, 8'h00, lat, rd, err);
    n_checks++;
    if (lat !== 1 || err !== 1'b0) begin
      n_fail++; $display("FAIL write_resp: got lat=%0d err=%b want 1/0", lat, err);
    end
    run_cmd(2'd1, 7'd5, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (lat !== 1 || rd !== 8'hA5 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL read_row5: got lat=%0d rdata=%h err=%b want 1/a5/0", lat, rd, err);
    end
  endtask

  task automatic test_compare();
    int lat; logic [WS-1:0] rd; logic err; logic [CQ-1:0] exp_tags;
    exp_tags = '0; exp_tags[3] = 1'b1; exp_tags[9] = 1'b1;
    run_cmd(2'd0, 7'd3, 8'h3C, 8'h00, lat, rd, err);
    run_cmd(2'd0, 7'd9, 8'h3C, 8'h00, lat, rd, err);
    run_cmd(2'd0, 7'd5, 8'h00, 8'h00, lat, rd, err);
    run_cmd(2'd2, 7'd0, 8'h3C, 8'hFF, lat, rd, err);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL compare_latency: got %0d want 2", lat);
    end
    n_checks++;
    if (tags !== exp_tags) begin
      n_fail++; $display("FAIL compare_tags: got %h want %h", tags, exp_tags);
    end
    n_checks++;
    if (any_match !== 1'b1 || first_idx !== 7'd3) begin
      n_fail++;
      $display("FAIL compare_summary: got any=%b first=%0d want 1/3", any_match, first_idx);
    end
`ifdef CAM_MATCH_COUNT_EN
    n_checks++;
    if (match_cnt !== 8'd2) begin
      n_fail++; $display("FAIL compare_count: got %0d want 2", match_cnt);
    end
`endif
  endtask

  task automatic test_tag_write();
    int lat; logic [WS-1:0] rd; logic err; logic [CQ-1:0] exp_tags;
    exp_tags = '0; exp_tags[3] = 1'b1; exp_tags[9] = 1'b1;
    run_cmd(2'd3, 7'd0, 8'h0F, 8'h0F, lat, rd, err);
    n_checks++;
    if (lat !== 1 || tags !== exp_tags) begin
      n_fail++; $display("FAIL tag_write_resp: got lat=%0d tags=%h want 1/%h", lat, tags, exp_tags);
    end
    run_cmd(2'd1, 7'd3, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (rd !== 8'h3F) begin
      n_fail++; $display("FAIL tag_write_row3: got %h want 3f", rd);
    end
    run_cmd(2'd1, 7'd9, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (rd !== 8'h3F) begin
      n_fail++; $display("FAIL tag_write_row9: got %h want 3f", rd);
    end
    run_cmd(2'd1, 7'd0, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++; $display("FAIL tag_write_row0: got %h want 00", rd);
    end
    n_checks++;
    if (any_match !== 1'b1 || first_idx !== 7'd3) begin
      n_fail++;
      $display("FAIL match_hold: got any=%b first=%0d want 1/3", any_match, first_idx);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [WS-1:0] rd; logic err;
    run_cmd(2'd0, 7'd120, 8'hFF, 8'h00, lat, rd, err);
    n_checks++;
    if (lat !== 1 || err !== 1'b1) begin
      n_fail++; $display("FAIL oob_write: got lat=%0d err=%b want 1/1", lat, err);
    end
    run_cmd(2'd1, 7'd120, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (rd !== 8'h00 || err !== 1'b1) begin
      n_fail++; $display("FAIL oob_read: got rdata=%h err=%b want 00/1", rd, err);
    end
    // No row may have picked up 0xFF from the ignored write.
    run_cmd(2'd2, 7'd0, 8'hFF, 8'hFF, lat, rd, err);
    n_checks++;
    if (tags !== '0 || any_match !== 1'b0 || first_idx !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_match: got tags=%h any=%b first=%0d err=%b want 0/0/0/0",
               tags, any_match, first_idx, err);
    end
    run_cmd(2'd3, 7'd0, 8'hFF, 8'hFF, lat, rd, err);
    run_cmd(2'd1, 7'd3, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (rd !== 8'h3F) begin
      n_fail++; $display("FAIL tag_write_none_row3: got %h want 3f", rd);
    end
    run_cmd(2'd2, 7'd0, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (lat !== 2 || tags !== {CQ{1'b1}}) begin
      n_fail++; $display("FAIL zero_mask_tags: got lat=%0d tags=%h want 2/all", lat, tags);
    end
    n_checks++;
    if (any_match !== 1'b1 || first_idx !== 7'd0) begin
      n_fail++;
      $display("FAIL zero_mask_summary: got any=%b first=%0d want 1/0", any_match, first_idx);
    end
`ifdef CAM_MATCH_COUNT_EN
    n_checks++;
    if (match_cnt !== 8'd100) begin
      n_fail++; $display("FAIL zero_mask_count: got %0d want 100", match_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    int lat; logic [WS-1:0] rd; logic err;
    send(2'd1, 7'd9, 8'h00, 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_checks++;
      if (resp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_handshake[%0d]: got valid=%b ready=%b want 1/0", c, resp_valid,
                 cmd_ready);
      end
      n_checks++;
      if (resp_rdata !== 8'h3F || resp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_data[%0d]: got rdata=%h err=%b want 3f/0", c, resp_rdata, resp_err);
      end
      // A command offered while busy must be ignored.
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 7'd9; cmd_data = 8'h00;
    end
    cmd_valid = 1'b0;
    finish_resp();
    run_cmd(2'd1, 7'd9, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (rd !== 8'h3F) begin
      n_fail++; $display("FAIL busy_cmd_ignored: got %h want 3f", rd);
    end
  endtask

  task automatic test_reset_in_flight();
    int lat; logic [WS-1:0] rd; logic err;
    send(2'd2, 7'd0, 8'h00, 8'h00);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    @(negedge clock);
    n_checks++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_flight_fsm: got valid=%b ready=%b want 0/1", resp_valid,
                         cmd_ready);
    end
    n_checks++;
    if (tags !== '0 || any_match !== 1'b0 || first_idx !== '0) begin
      n_fail++; $display("FAIL rst_flight_match: got tags=%h any=%b first=%0d want 0",
                         tags, any_match, first_idx);
    end
`ifdef CAM_MATCH_COUNT_EN
    n_checks++;
    if (match_cnt !== '0) begin
      n_fail++; $display("FAIL rst_flight_count: got %0d want 0", match_cnt);
    end
`endif
    repeat (3) @(negedge clock);
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_flight_no_resp: got %b want 0", resp_valid);
    end
    @(posedge clock);
    #1;
    run_cmd(2'd1, 7'd3, 8'h00, 8'h00, lat, rd, err);
    n_checks++;
    if (lat !== 1 || rd !== 8'h00) begin
      n_fail++; $display("FAIL rst_rows_cleared: got lat=%0d rdata=%h want 1/00", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_compare();
    test_tag_write();
    test_out_of_range();
    test_backpressure();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
